// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// followed by a single sign-fix/select cycle. Divide-by-zero and signed
// overflow bypass the iteration and complete in one cycle.
//
// state | meaning
// IDLE  | waiting for a request, ready=1
// CALC  | one radix-2 step per cycle, counter counts down to zero
// FIX   | sign correction and result selection
// DONE  | done pulse, result valid; may accept the next request
module muldiv_unit #(
    parameter int XLEN = 64,
    parameter bit W_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    localparam bit W_ACT = (XLEN == 64) && W_EN;
    localparam int CW    = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD = XLEN'($signed(32'h8000_0000));

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     cnt_q;
    logic [2:0]        f3_q;
    logic              w_q;
    logic              neg_q;
    logic              rneg_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvs_q;
    logic [XLEN-1:0]   result_q;
    logic              dbz_q;

    // Word results are the low 32 bits sign-extended to XLEN.
    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        return XLEN'($signed(v[31:0]));
    endfunction

    logic            accept;
    logic            w_op;
    logic            sgn_a;
    logic            sgn_b;
    logic [XLEN-1:0] ax;
    logic [XLEN-1:0] bx;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            is_dz;
    logic            is_ovf;
    logic            is_special;
    logic [XLEN-1:0] spec_res;
    logic [CW-1:0]   n_iter;

    assign accept = start && ready && !flush;

    // Request decode: operand extension, magnitudes and the one-cycle special cases.
    always_comb begin
        w_op   = W_ACT && op[3] && ((op[2:0] == 3'b000) || op[2]);
        sgn_a  = (op[2:0] == 3'b001) || (op[2:0] == 3'b010) ||
                 (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
        sgn_b  = (op[2:0] == 3'b001) || (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
        ax     = a;
        bx     = b;
        if (w_op) begin
            ax = sgn_a ? XLEN'($signed(a[31:0])) : XLEN'(a[31:0]);
            bx = sgn_b ? XLEN'($signed(b[31:0])) : XLEN'(b[31:0]);
        end
        neg_a      = sgn_a && ax[XLEN-1];
        neg_b      = sgn_b && bx[XLEN-1];
        mag_a      = neg_a ? -ax : ax;
        mag_b      = neg_b ? -bx : bx;
        is_dz      = op[2] && (bx == '0);
        is_ovf     = op[2] && !op[0] && !is_dz && (bx == '1) &&
                     (ax == (w_op ? MIN_WORD : MIN_FULL));
        is_special = is_dz || is_ovf;
        if (is_dz)
            spec_res = op[1] ? ax : '1;
        else
            spec_res = op[1] ? '0 : ax;
        if (w_op)
            spec_res = sext_w(spec_res);
        n_iter = w_op ? CW'(32) : CW'(XLEN);
    end

    logic [XLEN:0]     rem_sh;
    logic              fits;
    logic [XLEN-1:0]   rem_n;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_sel;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   sel;
    logic [XLEN-1:0]   fix_res;

    // Restoring-divide step and the final sign fix / result select.
    always_comb begin
        rem_sh  = {rem_q, quo_q[XLEN-1]};
        fits    = rem_sh >= {1'b0, dvs_q};
        rem_n   = fits ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
        prod    = neg_q ? -acc_q : acc_q;
        mul_sel = (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        quo_s   = neg_q ? -quo_q : quo_q;
        rem_s   = rneg_q ? -rem_q : rem_q;
        sel     = f3_q[2] ? (f3_q[1] ? rem_s : quo_s) : mul_sel;
        fix_res = w_q ? sext_w(sel) : sel;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; flush overrides everything, including a new request.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept)
                        state_d = is_special ? S_DONE : S_CALC;
                    else
                        state_d = S_IDLE;
                end
                S_CALC:  state_d = (cnt_q == CW'(1)) ? S_FIX : S_CALC;
                S_FIX:   state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Handshake outputs; a flush in DONE withdraws the pulse.
    always_comb begin
        ready = (state_q == S_IDLE) || (state_q == S_DONE);
        done  = (state_q == S_DONE) && !flush;
    end

    // Datapath: operand capture, iteration and result commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            w_q      <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            f3_q     <= op[2:0];
            w_q      <= w_op;
            neg_q    <= neg_a ^ neg_b;
            rneg_q   <= neg_a;
            acc_q    <= '0;
            mcand_q  <= {{XLEN{1'b0}}, mag_a};
            mplier_q <= mag_b;
            rem_q    <= '0;
            quo_q    <= w_op ? (mag_a << (XLEN - 32)) : mag_a;
            dvs_q    <= mag_b;
            cnt_q    <= is_special ? '0 : n_iter;
            if (is_special) begin
                result_q <= spec_res;
                dbz_q    <= is_dz;
            end
        end else if (state_q == S_CALC) begin
            if (mplier_q[0])
                acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            rem_q    <= rem_n;
            quo_q    <= {quo_q[XLEN-2:0], fits};
            cnt_q    <= cnt_q - CW'(1);
        end else if (state_q == S_FIX) begin
            result_q <= fix_res;
            dbz_q    <= 1'b0;
        end
    end

    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=64, word ops enabled).
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        flush;
    logic        ready;
    logic        done;
    logic [63:0] result;
    logic        div_by_zero;

    muldiv_unit #(.XLEN(64), .W_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .ready(ready), .done(done), .result(result),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          at;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic        d;
        int          lat;
        bit          pulse;
    } dir_t;
    dir_t dt[$];

    int checks = 0;
    int passed = 0;
    logic [63:0] last_res = '0;
    logic        last_dbz = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: plain arithmetic on the architectural rules.
    function automatic void model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                                  output logic [63:0] r, output logic dz, output int lat);
        logic [2:0]  f;
        bit          w;
        logic [127:0] px, py, p;
        logic [31:0] ux, uy, u32;
        logic [63:0] u64;
        f   = o[2:0];
        w   = o[3] && (f == 3'b000 || f[2]);
        dz  = 1'b0;
        lat = w ? 34 : 66;
        r   = '0;
        ux  = x[31:0];
        uy  = y[31:0];
        if (!f[2]) begin
            if (w) begin
                u32 = ux * uy;
                r   = {{32{u32[31]}}, u32};
            end else begin
                px = (f == 3'b001 || f == 3'b010) ? {{64{x[63]}}, x} : {64'd0, x};
                py = (f == 3'b001) ? {{64{y[63]}}, y} : {64'd0, y};
                p  = px * py;
                r  = (f == 3'b000) ? p[63:0] : p[127:64];
            end
        end else if (w) begin
            if (uy == 32'd0) begin
                dz = 1'b1; lat = 1;
                u32 = f[1] ? ux : 32'hFFFF_FFFF;
            end else if (!f[0] && ux == 32'h8000_0000 && uy == 32'hFFFF_FFFF) begin
                lat = 1;
                u32 = f[1] ? 32'd0 : ux;
            end else if (f[0]) begin
                u32 = f[1] ? (ux % uy) : (ux / uy);
            end else begin
                u32 = f[1] ? 32'($signed(ux) % $signed(uy)) : 32'($signed(ux) / $signed(uy));
            end
            r = {{32{u32[31]}}, u32};
        end else begin
            if (y == 64'd0) begin
                dz = 1'b1; lat = 1;
                r = f[1] ? x : '1;
            end else if (!f[0] && x == 64'h8000_0000_0000_0000 && y == '1) begin
                lat = 1;
                r = f[1] ? 64'd0 : x;
            end else if (f[0]) begin
                r = f[1] ? (x % y) : (x / y);
            end else begin
                u64 = f[1] ? 64'($signed(x) % $signed(y)) : 64'($signed(x) / $signed(y));
                r = u64;
            end
        end
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h0000_0000_8000_0000;
            4: return 64'($urandom_range(0, 20));
            5: return {$urandom, 32'h0};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
                check("done_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    // Called at a negedge; waits for ready, presents one request for one edge.
    task automatic issue(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] er, input logic ed, input int el, input bit push);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1)
            check("ready_timeout", {63'd0, ready}, 64'd1);
        start = 1'b1; op = o; a = x; b = y;
        if (push) begin
            sb.push_back('{er, ed, cyc + el});
            last_res = er;
            last_dbz = ed;
        end
        @(negedge clk);
        start = 1'b0;
        op = 4'($urandom);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [3:0]  ro;
        logic [63:0] ra, rb, rr;
        logic        rd;
        int          rl;

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        dt.push_back('{4'b0000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 66, 1'b0});
        dt.push_back('{4'b0011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66, 1'b0});
        dt.push_back('{4'b0001, '1, '1, 64'd0, 1'b0, 66, 1'b0});
        dt.push_back('{4'b0010, '1, '1, '1, 1'b0, 66, 1'b0});
        dt.push_back('{4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 66, 1'b0});
        dt.push_back('{4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 1'b0, 66, 1'b0});
        dt.push_back('{4'b0101, 64'd5, 64'd0, '1, 1'b1, 1, 1'b0});
        dt.push_back('{4'b0111, 64'd5, 64'd0, 64'd5, 1'b1, 1, 1'b0});
        dt.push_back('{4'b0100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b0, 1, 1'b0});
        dt.push_back('{4'b0110, 64'h8000_0000_0000_0000, '1, 64'd0, 1'b0, 1, 1'b0});
        dt.push_back('{4'b1100, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1, 1'b0});
        dt.push_back('{4'b1101, 64'h0000_0001_0000_0010, 64'd4, 64'd4, 1'b0, 34, 1'b1});
        dt.push_back('{4'b1000, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 34, 1'b0});
        dt.push_back('{4'b1011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66, 1'b0});
        dt.push_back('{4'b1110, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 1'b0, 34, 1'b0});
        dt.push_back('{4'b1111, 64'h0000_0000_8000_0005, 64'h0000_0001_0000_0000,
                       64'hFFFF_FFFF_8000_0005, 1'b1, 1, 1'b0});
        dt.push_back('{4'b0101, '1, 64'd3, 64'h5555_5555_5555_5555, 1'b0, 66, 1'b0});

        repeat (2) @(negedge clk);
        check("rst_ready", {63'd0, ready}, 64'd1);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < dt.size(); i++) begin
            issue(dt[i].op, dt[i].a, dt[i].b, dt[i].r, dt[i].d, dt[i].lat, 1'b1);
            if (dt[i].pulse) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("busy_not_ready", {63'd0, ready}, 64'd0);
                    start = 1'b1; op = 4'b0101; a = {$urandom, $urandom}; b = 64'd0;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        end
        drain();

        // Flush mid-calculation: no done, result and flag untouched.
        issue(4'b0000, 64'd12345, 64'd678, 64'd0, 1'b0, 0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", {63'd0, ready}, 64'd1);
        check("flush_result_held", result, last_res);
        check("flush_dbz_held", {63'd0, div_by_zero}, {63'd0, last_dbz});
        repeat (80) @(negedge clk);

        // Asynchronous reset mid-calculation.
        issue(4'b0100, 64'd1000, 64'd7, 64'd0, 1'b0, 0, 1'b0);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("areset_ready", {63'd0, ready}, 64'd1);
        check("areset_done", {63'd0, done}, 64'd0);
        check("areset_result", result, 64'd0);
        check("areset_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {63'd0, ready}, 64'd1);
        repeat (80) @(negedge clk);

        // Randomized traffic, including back-to-back issue from DONE.
        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom);
            ra = pick();
            rb = pick();
            model(ro, ra, rb, rr, rd, rl);
            issue(ro, ra, rb, rr, rd, rl, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 64, operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter: W_EN, 1, enables RV64 word ops (op[3]); forced inactive when XLEN=32.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  request; accepted on a rising edge when start=1 and ready=1.
REQ-006 SHALL have port: op  input  4  op[2:0]=funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU); op[3]=word (W) op.
REQ-007 SHALL have port: a  input  XLEN  operand rs1, sampled at accept only.
REQ-008 SHALL have port: b  input  XLEN  operand rs2, sampled at accept only.
REQ-009 SHALL have port: flush  input  1  abort in-flight operation.
REQ-010 SHALL have port: ready  output  1  unit can accept a request.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port: result  output  XLEN  registered result, held until next done.
REQ-013 SHALL have port: div_by_zero  output  1  registered flag, valid with done, held with result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE; ready=1 only in IDLE and DONE.
REQ-015 SHALL on accept: latch op, a, b; go to DONE directly for special cases (REQ-020..022), else to CALC with iteration counter = N (N=32 for W ops, XLEN otherwise).
REQ-016 SHALL in CALC perform one radix-2 step per cycle (shift-add multiply, restoring divide on operand magnitudes); decrement counter; go to FIX when counter reaches 0 after the step.
REQ-017 SHALL in FIX apply sign correction and result selection in one cycle, then go to DONE.
REQ-018 SHALL in DONE assert done for exactly one cycle; next state IDLE, or CALC/DONE if a new request is accepted in that same cycle (back-to-back).
REQ-019 SHALL give latency accept-edge to done-high: N+2 cycles normal, 1 cycle special cases.
REQ-020 SHALL on divide by zero: DIV/DIVU quotient = all ones, REM/REMU remainder = a; div_by_zero=1; 1-cycle latency.
REQ-021 SHALL on signed overflow (a = most-negative, b = -1, DIV/REM): quotient = a, remainder = 0; div_by_zero=0; 1-cycle latency.
REQ-022 SHALL treat W with funct3 001/010/011, or W when XLEN=32/W_EN=0, as: W ignored for MULH*; when W_EN=0 all W ops execute as full-width.
REQ-023 SHALL for W ops use a[31:0], b[31:0] (signed or unsigned per funct3) and sign-extend bit 31 of the 32-bit result to XLEN, including REQ-020/021 cases evaluated at 32 bits.
REQ-024 SHALL produce MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits of 2*XLEN product (signed*signed, signed*unsigned, unsigned*unsigned).
REQ-025 SHALL give remainder the sign of the dividend and quotient truncated toward zero (signed ops).
REQ-026 SHALL ignore start while busy (CALC/FIX); operands not sampled.
REQ-027 SHALL on flush=1 in any state go to IDLE next edge, suppress done, leave result/div_by_zero unchanged; flush has priority over simultaneous start.

Reset
REQ-028 SHALL on reset=1 immediately force IDLE, ready=1, done=0, result=0, div_by_zero=0, counter=0; reset mid-operation discards the operation with no done.

Verification
REQ-029 SHALL verify XLEN=64: MUL a=-3, b=7 -> done at accept+66, result=0xFFFF_FFFF_FFFF_FFEB; MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE.
REQ-030 SHALL verify DIV a=-7, b=2 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD); REM same operands -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-031 SHALL verify DIVU a=5, b=0 -> done at accept+1, result=all ones, div_by_zero=1; REMU same -> result=5.
REQ-032 SHALL verify DIV a=0x8000_0000_0000_0000, b=-1 -> result=a, done at accept+1; DIVW a=0x8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000.
REQ-033 SHALL verify DIVUW a=0x1_0000_0010, b=4 -> result=4, done at accept+34; start pulses during CALC ignored.
REQ-034 SHALL verify flush at accept+10 and reset at accept+20 of a second op -> no done, ready=1 next cycle, result holds prior value (after reset: 0).
